pcie_dma_writer: RTL

PCIE_DMA_WRITER -- requirements
Module: pcie_dma_writer

---
 rtl/pcie_dma_writer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pcie_dma_writer.sv
// PCIe DMA writer: N 128-byte MWr TLPs from a QW source, plus a completion token TLP when PCIE_DMA_COMPLETION_TOKEN_EN.
// Latency: first HDR0 one cycle after the DMACTRL write; payload passes through combinationally in DATA.
// Backpressure: txReady_in feeds srcReady_out in DATA; header/token beats hold stable until accepted.
module pcie_dma_writer #(
    parameter logic [63:0] TOKEN      = 64'hCAFEF00DC0DEFACE,
    parameter int unsigned QW_PER_TLP = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        regWrValid_in,
    input  logic [4:0]  regWrAddr_in,
    input  logic [31:0] regWrData_in,
    input  logic [15:0] cfgBusDev_in,
    input  logic [63:0] srcData_in,
    input  logic        srcValid_in,
    output logic        srcReady_out,
    output logic [63:0] txData_out,
    output logic        txValid_out,
    output logic        txSOP_out,
    output logic        txEOP_out,
    input  logic        txReady_in,
    output logic        busy_out,
    output logic        done_out
);
    localparam int unsigned     QW_W        = (QW_PER_TLP > 1) ? $clog2(QW_PER_TLP) : 1;
    localparam logic [QW_W-1:0] QW_LAST     = QW_W'(QW_PER_TLP - 1);
    localparam logic [9:0]      DATA_LEN_DW = 10'(2 * QW_PER_TLP);
    localparam logic [31:0]     TLP_BYTES   = 32'(8 * QW_PER_TLP);
    localparam logic [31:0]     DATA_OFS    = 32'h0000_0040;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
`ifdef PCIE_DMA_COMPLETION_TOKEN_EN
        DATA,
        TOK0,
        TOK1,
        TOKD
`else
        DATA
`endif
    } state_t;

`ifndef PCIE_DMA_COMPLETION_TOKEN_EN
    // The token payload has no consumer when the completion TLP is compiled out.
    localparam logic [63:0] TOKEN_UNUSED = TOKEN;
`endif

    state_t          state_q, state_d;
    logic [31:0]     base_q, base_d;
    logic [31:0]     addr_q, addr_d;
    logic [15:0]     n_q, n_d;
    logic [15:0]     tlp_q, tlp_d;
    logic [QW_W-1:0] qw_q, qw_d;
    logic            done_q, done_d;

    logic idle;
    logic wr_base;
    logic wr_ctrl;

    // 3DW MWr header beat: {DW1, DW0}, DW0 = R|fmt 2'b10|type 0|TC 0|attrs 0|length.
    function automatic logic [63:0] hdr0_beat(input logic [9:0] len_dw, input logic [15:0] rid);
        return {rid, 8'h00, 4'hF, 4'hF,
                1'b0, 2'b10, 5'b00000, 1'b0, 3'b000, 4'b0000,
                1'b0, 1'b0, 2'b00, 2'b00, len_dw};
    endfunction

    // The done cycle still counts as busy, so register writes then are dropped.
    assign idle    = (state_q == IDLE) && !done_q;
    assign wr_base = regWrValid_in && (regWrAddr_in == 5'd0) && idle;
    assign wr_ctrl = regWrValid_in && (regWrAddr_in == 5'd1) && idle && (regWrData_in[15:0] != 16'd0);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            n_q     <= '0;
            tlp_q   <= '0;
            qw_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            n_q     <= n_d;
            tlp_q   <= tlp_d;
            qw_q    <= qw_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        addr_d       = addr_q;
        n_d          = n_q;
        tlp_d        = tlp_q;
        qw_d         = qw_q;
        done_d       = 1'b0;
        txData_out   = '0;
        txValid_out  = 1'b0;
        txSOP_out    = 1'b0;
        txEOP_out    = 1'b0;
        srcReady_out = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_base) begin
                    base_d = {regWrData_in[31:3], 3'b000};
                end
                if (wr_ctrl) begin
                    n_d     = regWrData_in[15:0];
                    tlp_d   = '0;
                    qw_d    = '0;
                    addr_d  = base_q + DATA_OFS;
                    state_d = HDR0;
                end
            end
            HDR0: begin
                txData_out  = hdr0_beat(DATA_LEN_DW, cfgBusDev_in);
                txValid_out = 1'b1;
                txSOP_out   = 1'b1;
                if (txReady_in) begin
                    state_d = HDR1;
                end
            end
            HDR1: begin
                txData_out  = {32'h0, addr_q};
                txValid_out = 1'b1;
                if (txReady_in) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                txData_out   = srcData_in;
                txValid_out  = srcValid_in;
                srcReady_out = txReady_in;
                txEOP_out    = (qw_q == QW_LAST);
                if (srcValid_in && txReady_in) begin
                    if (qw_q == QW_LAST) begin
                        qw_d   = '0;
                        addr_d = addr_q + TLP_BYTES;
                        tlp_d  = tlp_q + 16'd1;
                        if (tlp_q == n_q - 16'd1) begin
`ifdef PCIE_DMA_COMPLETION_TOKEN_EN
                            state_d = TOK0;
`else
                            state_d = IDLE;
                            done_d  = 1'b1;
`endif
                        end else begin
                            state_d = HDR0;
                        end
                    end else begin
                        qw_d = qw_q + 1'b1;
                    end
                end
            end
`ifdef PCIE_DMA_COMPLETION_TOKEN_EN
            TOK0: begin
                txData_out  = hdr0_beat(10'd2, cfgBusDev_in);
                txValid_out = 1'b1;
                txSOP_out   = 1'b1;
                if (txReady_in) begin
                    state_d = TOK1;
                end
            end
            TOK1: begin
                txData_out  = {32'h0, base_q};
                txValid_out = 1'b1;
                if (txReady_in) begin
                    state_d = TOKD;
                end
            end
            TOKD: begin
                txData_out  = TOKEN;
                txValid_out = 1'b1;
                txEOP_out   = 1'b1;
                if (txReady_in) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_out = (state_q != IDLE) || done_q;
    assign done_out = done_q;

endmodule
